reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised scoreboard-based hazard unit for the RISC-V pipeline; successor to the purely combinational hazard logic.
- Sits beside decode. Tracks pending destination-register writes from two kinds of ops:
  - fixed-latency ops, e.g. loads;
  - variable-latency ops, e.g. iterative mul/div, which complete via a writeback pulse.
- Asserts stall when a decoding instruction reads, or write-after-writes, a not-yet-forwardable register; enforces a cap on outstanding variable-latency ops.

Parameters:
- NREG, 32, number of architectural registers (x0 hard-wired zero, never tracked)
- AW, $clog2(NREG), register address width
- MAX_LAT, 3, largest fixed latency (stall cycles) an issue may request
- CW, $clog2(MAX_LAT+1), per-register countdown width
- MAX_UNK, 4, max outstanding variable-latency ops
- UW, $clog2(MAX_UNK+1), outstanding-count width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets at clk edge)
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1  in  AW  source 1 address
- issue_rs1_used  in  1  source 1 is read
- issue_rs2  in  AW  source 2 address
- issue_rs2_used  in  1  source 2 is read
- issue_rd  in  AW  destination address
- issue_wen  in  1  instruction writes rd
- issue_lat_known  in  1  1 = fixed latency, 0 = variable latency
- issue_lat  in  CW  stall cycles a back-to-back dependent needs (0 = fully forwardable)
- flushD  in  1  decode instruction is squashed (branch/jump)
- ext_stall  in  1  whole-pipeline freeze (e.g. memory wait)
- cmpl_valid  in  1  variable-latency op writes back this cycle
- cmpl_rd  in  AW  its destination
- stall  out  1  hold fetch/decode, bubble into execute
- issue_fire  out  1  decode instruction accepted this cycle
- busy  out  NREG  per-register pending (cnt!=0 or unk)
- unk_count  out  UW  outstanding variable-latency ops
- err  out  1  sticky: completion for a register with no pending unknown op

Behaviour:
- State per register r (1..NREG-1): cnt[r] (CW bits), unk[r] (1 bit); unk_count; err. Entry 0 is constant zero.
- Reset (rst=0 at edge): all cnt=0, unk=0, unk_count=0, err=0. Hence stall=0, issue_fire=0 unless issue_valid, busy=0. Reset mid-operation discards all pending state; it overrides any simultaneous issue or completion.
- Source hazard (combinational from registered state): src_haz = used && addr!=0 && (cnt[addr]!=0 || unk[addr]).
- WAW hazard: issue_wen && rd!=0 && unk[rd].
- Capacity hazard: issue_wen && !issue_lat_known && unk_count==MAX_UNK.
- stall = issue_valid && !flushD && (any hazard). stall does not depend on ext_stall.
- issue_fire = issue_valid && !flushD && !stall && !ext_stall.
- Countdown: if !ext_stall, every nonzero cnt decrements by 1 each cycle. ext_stall freezes all cnt.
- On issue_fire with issue_wen, rd!=0:
  - lat_known: cnt[rd] = min(issue_lat, MAX_LAT); issue_lat=0 records nothing.
  - Otherwise: unk[rd]=1, unk_count+1.
  - An issue write takes priority over the same-cycle decrement of that entry.
- Completion: cmpl_valid with cmpl_rd!=0 and unk[cmpl_rd]=1 clears unk and decrements unk_count. It is honoured even when ext_stall=1.
- Completion to a non-pending register or x0: state unchanged, err=1 (sticky until reset).
- Same-cycle completion and unknown issue: unk_count net unchanged. Same rd cannot occur (WAW stall).
- Latency: a dependent sees stall drop in the cycle after the countdown reaches 0, or after the cycle carrying cmpl_valid.
- flushD suppresses stall and issue_fire only; already-issued (older) entries are untouched.

Test Plan:
1. Load issue rd=5, lat=1; next cycle add rs1=5 used -> stall=1 for one cycle, issue_fire=1 the following cycle; busy[5] 1 then 0.
2. Issue rd=0, lat=3, then a read of x0 -> stall=0, busy=0, issue_fire=1 both cycles.
3. Div rd=7 unknown; dependent rs2=7 held 10 cycles -> stall=1 throughout; cmpl_valid rd=7 on cycle 10 -> stall=0, issue_fire=1 on cycle 11; unk_count 1→0.
4. Four unknown issues rd=1..4 -> unk_count=4; fifth unknown rd=6 -> stall=1; cmpl rd=2 -> fifth fires next cycle, unk_count back to 4. WAW issue to rd=3 stalls until cmpl rd=3.
5. lat=2 to rd=9, then ext_stall=1 for 3 cycles -> cnt[9] stays 2. After release, dependent stalls exactly 2 further cycles.
6. cmpl_valid rd=12 with nothing pending -> err=1, persists. rst=0 one edge with busy nonzero -> busy=0, unk_count=0, err=0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Scoreboard hazard unit beside decode: tracks pending register writes from fixed-latency
// (countdown) and variable-latency (writeback-completed) ops and stalls dependent issues.
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int MAX_LAT = 3,
    parameter int CW      = $clog2(MAX_LAT + 1),
    parameter int MAX_UNK = 4,
    parameter int UW      = $clog2(MAX_UNK + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic            issue_rs1_used,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_rs2_used,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_wen,
    input  logic            issue_lat_known,
    input  logic [CW-1:0]   issue_lat,
    input  logic            flushD,
    input  logic            ext_stall,
    input  logic            cmpl_valid,
    input  logic [AW-1:0]   cmpl_rd,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy,
    output logic [UW-1:0]   unk_count,
    output logic            err
);

    logic [CW-1:0] r_cnt [NREG];
    logic [NREG-1:0] r_unk;
    logic [UW-1:0]   r_unk_count;
    logic            r_err;

    logic          w_rs1_haz;
    logic          w_rs2_haz;
    logic          w_waw_haz;
    logic          w_cap_haz;
    logic          w_rd_nz;
    logic          w_set_cnt;
    logic          w_set_unk;
    logic          w_cmpl_ok;
    logic [CW-1:0] w_lat;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (r_cnt[i] != '0) || r_unk[i];
        end
    end

    always_comb begin
        w_rd_nz    = issue_rd != '0;
        w_rs1_haz  = issue_rs1_used && (issue_rs1 != '0) && busy[issue_rs1];
        w_rs2_haz  = issue_rs2_used && (issue_rs2 != '0) && busy[issue_rs2];
        w_waw_haz  = issue_wen && w_rd_nz && r_unk[issue_rd];
        w_cap_haz  = issue_wen && !issue_lat_known && (r_unk_count == UW'(MAX_UNK));
        stall      = issue_valid && !flushD && (w_rs1_haz || w_rs2_haz || w_waw_haz || w_cap_haz);
        issue_fire = issue_valid && !flushD && !stall && !ext_stall;
        w_lat      = (int'(issue_lat) > MAX_LAT) ? CW'(MAX_LAT) : issue_lat;
        // A zero latency is fully forwardable, so it must not overwrite an older countdown.
        w_set_cnt  = issue_fire && issue_wen && w_rd_nz && issue_lat_known && (issue_lat != '0);
        w_set_unk  = issue_fire && issue_wen && w_rd_nz && !issue_lat_known;
        w_cmpl_ok  = cmpl_valid && (cmpl_rd != '0) && r_unk[cmpl_rd];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_unk       <= '0;
            r_unk_count <= '0;
            r_err       <= 1'b0;
        end else begin
            // Entry 0 is never written, so it stays at its reset value of zero.
            for (int i = 1; i < NREG; i++) begin
                if (w_set_cnt && (issue_rd == AW'(i))) begin
                    r_cnt[i] <= w_lat;
                end else if (!ext_stall && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
                if (w_set_unk && (issue_rd == AW'(i))) begin
                    r_unk[i] <= 1'b1;
                end else if (w_cmpl_ok && (cmpl_rd == AW'(i))) begin
                    r_unk[i] <= 1'b0;
                end
            end
            case ({w_set_unk, w_cmpl_ok})
                2'b10:   r_unk_count <= r_unk_count + 1'b1;
                2'b01:   r_unk_count <= r_unk_count - 1'b1;
                default: r_unk_count <= r_unk_count;
            endcase
            if (cmpl_valid && !w_cmpl_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign unk_count = r_unk_count;
    assign err       = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: per-cycle stimulus with expected outputs queued
// at drive time and popped for comparison once the outputs settle.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_used;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        issue_lat_known;
    logic [1:0]  issue_lat;
    logic        flushD;
    logic        ext_stall;
    logic        cmpl_valid;
    logic [4:0]  cmpl_rd;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
    logic [2:0]  unk_count;
    logic        err;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wen;
        logic        lk;
        logic [1:0]  lat;
        logic        fl;
        logic        ex;
        logic        cv;
        logic [4:0]  crd;
        logic        rn;
    } stim_t;

    typedef struct packed {
        logic        s;
        logic        f;
        logic [31:0] b;
        logic [2:0]  u;
        logic        e;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t got;
    int   n_err = 0;
    int   n_checks = 0;

    reg_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs1_used  (issue_rs1_used),
        .issue_rs2       (issue_rs2),
        .issue_rs2_used  (issue_rs2_used),
        .issue_rd        (issue_rd),
        .issue_wen       (issue_wen),
        .issue_lat_known (issue_lat_known),
        .issue_lat       (issue_lat),
        .flushD          (flushD),
        .ext_stall       (ext_stall),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rd         (cmpl_rd),
        .stall           (stall),
        .issue_fire      (issue_fire),
        .busy            (busy),
        .unk_count       (unk_count),
        .err             (err)
    );

    always #5 clk = ~clk;

    always_comb got = {stall, issue_fire, busy, unk_count, err};

    function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic wen, input logic lk, input logic [1:0] lat,
                                 input logic fl, input logic ex, input logic cv,
                                 input logic [4:0] crd, input logic rn);
        return {v, rs1, u1, rs2, u2, rd, wen, lk, lat, fl, ex, cv, crd, rn};
    endfunction

    function automatic exp_t xp(input logic s, input logic f, input logic [31:0] b,
                                input logic [2:0] u, input logic er);
        return {s, f, b, u, er};
    endfunction

    // Shorthands: idle cycle, and idle cycle with a completion pulse.
    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic stim_t cmpl(input logic [4:0] rd);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd, 1);
    endfunction

    task automatic apply(input stim_t s);
        issue_valid     = s.v;
        issue_rs1       = s.rs1;
        issue_rs1_used  = s.u1;
        issue_rs2       = s.rs2;
        issue_rs2_used  = s.u2;
        issue_rd        = s.rd;
        issue_wen       = s.wen;
        issue_lat_known = s.lk;
        issue_lat       = s.lat;
        flushD          = s.fl;
        ext_stall       = s.ex;
        cmpl_valid      = s.cv;
        cmpl_rd         = s.crd;
        rst             = s.rn;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(xp(0, 0, 0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(xp(0, 0, 0, 0, 0));
        st.push_back(mk(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_fixed_lat();
        stim_t st[$];
        exp_t  ex[$];
        // load x5 lat1, then dependent add rs1=x5 (writes x6 lat0)
        st.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        st.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h20, 0, 0));
        st.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        // x0 destination with lat3 is never tracked
        st.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        st.push_back(mk(1, 0, 1, 0, 1, 8, 0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        st.push_back(idle());                                        ex.push_back(xp(0, 0, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL fixed_lat c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_var_lat();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            st.push_back(mk(1, 0, 0, 7, 1, 8, 1, 1, 0, 0, 0, 0, 0, 1));
            ex.push_back(xp(1, 0, 32'h80, 1, 0));
        end
        st.push_back(mk(1, 0, 0, 7, 1, 8, 1, 1, 0, 0, 0, 1, 7, 1)); ex.push_back(xp(1, 0, 32'h80, 1, 0));
        st.push_back(mk(1, 0, 0, 7, 1, 8, 1, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL var_lat c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_capacity_waw();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 32'h02, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 32'h06, 2, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 32'h0E, 3, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h1E, 4, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 2, 1)); ex.push_back(xp(1, 0, 32'h1E, 4, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 32'h1A, 3, 0));
        // WAW on x3 holds until its completion lands
        st.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h5A, 4, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 3, 1)); ex.push_back(xp(1, 0, 32'h5A, 4, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 32'h52, 3, 0));
        // unknown issue and completion in one cycle leave the count unchanged
        st.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 1, 1)); ex.push_back(xp(0, 1, 32'h52, 3, 0));
        st.push_back(cmpl(4));                                        ex.push_back(xp(0, 0, 32'h450, 3, 0));
        st.push_back(cmpl(6));                                        ex.push_back(xp(0, 0, 32'h440, 2, 0));
        st.push_back(cmpl(10));                                       ex.push_back(xp(0, 0, 32'h400, 1, 0));
        st.push_back(idle());                                         ex.push_back(xp(0, 0, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL capacity_waw c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_ext_stall();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 2, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        // an unrelated valid instruction during the freeze neither stalls nor fires
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); ex.push_back(xp(0, 0, 32'h200, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); ex.push_back(xp(0, 0, 32'h200, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); ex.push_back(xp(0, 0, 32'h200, 0, 0));
        st.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h200, 0, 0));
        st.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h200, 0, 0));
        st.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL ext_stall c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(mk(1, 0, 0, 0, 0, 11, 1, 1, 3, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        st.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1)); ex.push_back(xp(0, 0, 32'h800, 0, 0));
        st.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h800, 0, 0));
        st.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(1, 0, 32'h800, 0, 0));
        st.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(xp(0, 1, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL flush c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    task automatic test_err_and_reset();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(cmpl(12));                                        ex.push_back(xp(0, 0, 0, 0, 0));
        st.push_back(idle());                                          ex.push_back(xp(0, 0, 0, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 1));  ex.push_back(xp(0, 1, 0, 0, 1));
        // reset edge discards the pending op and the simultaneous issue
        st.push_back(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(xp(0, 1, 32'h2000, 1, 1));
        st.push_back(idle());                                          ex.push_back(xp(0, 0, 0, 0, 0));
        st.push_back(cmpl(0));                                         ex.push_back(xp(0, 0, 0, 0, 0));
        st.push_back(idle());                                          ex.push_back(xp(0, 0, 0, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   ex.push_back(xp(0, 0, 0, 0, 1));
        st.push_back(idle());                                          ex.push_back(xp(0, 0, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk); apply(st[i]); q.push_back(ex[i]); #1;
            e = q.pop_front(); n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL err_reset c%0d: got s=%b f=%b busy=%h unk=%0d err=%b want s=%b f=%b busy=%h unk=%0d err=%b",
                         i, got.s, got.f, got.b, got.u, got.e, e.s, e.f, e.b, e.u, e.e);
            end
        end
    endtask

    initial begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_fixed_lat();
        test_var_lat();
        test_capacity_waw();
        test_ext_stall();
        test_flush();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
